// File: rtl/hazard_ctrl_mc_pkg.sv
// Shared encodings for the hazard controller: writeback sources, jump selects,
// controller states and the packed bubble/stall control bundle.
package hazard_ctrl_mc_pkg;

  // Writeback source select of the EX instruction
  localparam logic [1:0] REGSRC_ALU  = 2'd0;
  localparam logic [1:0] REGSRC_MEM  = 2'd1;
  localparam logic [1:0] REGSRC_PC4  = 2'd2;
  localparam logic [1:0] REGSRC_MEMU = 2'd3;

  // Jump target select in MEM; PJUMP_PC4 means the predicted path was right
  localparam logic [1:0] PJUMP_PC4   = 2'd0;
  localparam logic [1:0] JSEL_BRANCH = 2'd1;
  localparam logic [1:0] JSEL_JAL    = 2'd2;
  localparam logic [1:0] JSEL_JALR   = 2'd3;

  typedef enum logic [1:0] {
    HZ_IDLE    = 2'd0,
    HZ_MULDIV  = 2'd1,
    HZ_MEMWAIT = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic s_pc;
    logic b_ifid;
    logic b_idie;
    logic b_ieme;
    logic b_mewb;
    logic s_ifid;
    logic s_idie;
    logic s_ieme;
    logic s_mewb;
  } hz_ctl_t;

  // Writeback data comes from data memory, so it is not forwardable from EX
  function automatic logic is_mem_src(input logic [1:0] src);
    return (src == REGSRC_MEM) || (src == REGSRC_MEMU);
  endfunction

endpackage

// File: rtl/hazard_ctrl_mc_muldiv_occupancy.sv
// Remaining-cycle counter for a multi-cycle mul/div/rem held in EX.
// The entry cycle is the first stall, so a load sets MULDIV_LAT-2 remaining.
module muldiv_occupancy #(
  parameter int MULDIV_LAT = 4,
  localparam int CW = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  input  logic abort,
  output logic busy
);

  localparam logic [CW-1:0] LOAD_VAL = CW'(MULDIV_LAT - 2);

  logic [CW-1:0] cnt_r;

  // Counter update: abort beats load beats decrement; otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (abort) begin
      cnt_r <= {CW{1'b0}};
    end else if (load) begin
      cnt_r <= LOAD_VAL;
    end else if (dec && (cnt_r != {CW{1'b0}})) begin
      cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign busy = (cnt_r != {CW{1'b0}});

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Central stall/bubble controller: memory-wait freeze, jump flush, multi-cycle
// mul/div occupancy, load-use bubble and fetch bubble, plus a stall-cycle counter.
module hazard_ctrl_mc
  import hazard_ctrl_mc_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int MULDIV_LAT = 4,
  parameter int PERF_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1s2,
  input  logic [REG_AW-1:0] rs2s2,
  input  logic              useRs1s2,
  input  logic              useRs2s2,
  input  logic [REG_AW-1:0] rds3,
  input  logic              regesterWs3,
  input  logic [1:0]        regSrcs3,
  input  logic              muldivs3,
  input  logic              jumps4,
  input  logic [1:0]        jumpSels4,
  input  logic              imem_ready,
  input  logic              dmem_reqs4,
  input  logic              dmem_ready,
  output logic              s_PC,
  output logic              b_IFID,
  output logic              b_IDIE,
  output logic              b_IEME,
  output logic              b_MEWB,
  output logic              s_IFID,
  output logic              s_IDIE,
  output logic              s_IEME,
  output logic              s_MEWB,
  output logic [PERF_W-1:0] stall_cnt
);

  hz_state_e     state_r, state_nxt_s;
  hz_state_e     saved_r, saved_nxt_s;
  hz_state_e     eff_state_s;
  hz_ctl_t       ctl_s;
  logic          jumped_s;
  logic          loaduse_s;
  logic          freeze_s;
  logic          md_load_s;
  logic          md_dec_s;
  logic          md_abort_s;
  logic          md_busy_s;
  logic          any_stall_s;
  logic [PERF_W-1:0] stall_cnt_r;

  assign jumped_s  = jumps4 && (jumpSels4 != PJUMP_PC4);
  assign loaduse_s = regesterWs3 && (rds3 != {REG_AW{1'b0}}) && is_mem_src(regSrcs3) &&
                     ((useRs1s2 && (rs1s2 == rds3)) || (useRs2s2 && (rs2s2 == rds3)));
  // MEMWAIT keeps freezing until dmem_ready, even if the request line wobbles
  assign freeze_s  = ((state_r == HZ_MEMWAIT) || dmem_reqs4) && !dmem_ready;

  muldiv_occupancy #(
    .MULDIV_LAT (MULDIV_LAT)
  ) u_occ (
    .clk   (clk),
    .rst   (rst),
    .load  (md_load_s),
    .dec   (md_dec_s),
    .abort (md_abort_s),
    .busy  (md_busy_s)
  );

  // Next-state and priority mux for all bubble/stall controls
  always_comb begin
    ctl_s       = '0;
    state_nxt_s = state_r;
    saved_nxt_s = saved_r;
    md_load_s   = 1'b0;
    md_dec_s    = 1'b0;
    md_abort_s  = 1'b0;
    // On the release cycle the controller behaves as the state it left
    eff_state_s = (state_r == HZ_MEMWAIT) ? saved_r : state_r;

    if (rst) begin
      ctl_s.b_ifid = 1'b1;
      ctl_s.b_idie = 1'b1;
      ctl_s.b_ieme = 1'b1;
      ctl_s.b_mewb = 1'b1;
    end else if (freeze_s) begin
      ctl_s.s_pc   = 1'b1;
      ctl_s.s_ifid = 1'b1;
      ctl_s.s_idie = 1'b1;
      ctl_s.s_ieme = 1'b1;
      ctl_s.s_mewb = 1'b1;
      if (state_r != HZ_MEMWAIT) begin
        saved_nxt_s = state_r;
        state_nxt_s = HZ_MEMWAIT;
      end else begin
        saved_nxt_s = saved_r;
        state_nxt_s = HZ_MEMWAIT;
      end
    end else if (jumped_s) begin
      ctl_s.b_ifid = 1'b1;
      ctl_s.b_idie = 1'b1;
      ctl_s.b_ieme = 1'b1;
      md_abort_s   = (eff_state_s == HZ_MULDIV);
      state_nxt_s  = HZ_IDLE;
    end else if (((eff_state_s == HZ_MULDIV) && md_busy_s) ||
                 ((eff_state_s == HZ_IDLE) && muldivs3)) begin
      ctl_s.s_pc   = 1'b1;
      ctl_s.s_ifid = 1'b1;
      ctl_s.s_idie = 1'b1;
      ctl_s.b_ieme = 1'b1;
      md_load_s    = (eff_state_s == HZ_IDLE);
      md_dec_s     = (eff_state_s == HZ_MULDIV);
      state_nxt_s  = HZ_MULDIV;
    end else begin
      // Covers the final mul/div cycle as well as plain IDLE
      state_nxt_s = HZ_IDLE;
      if (loaduse_s) begin
        ctl_s.s_pc   = 1'b1;
        ctl_s.s_ifid = 1'b1;
        ctl_s.b_idie = 1'b1;
      end else if (!imem_ready) begin
        ctl_s.s_pc   = 1'b1;
        ctl_s.b_ifid = 1'b1;
      end else begin
        ctl_s = '0;
      end
    end
  end

  // State and saved-state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= HZ_IDLE;
      saved_r <= HZ_IDLE;
    end else begin
      state_r <= state_nxt_s;
      saved_r <= saved_nxt_s;
    end
  end

  assign any_stall_s = ctl_s.s_pc | ctl_s.s_ifid | ctl_s.s_idie | ctl_s.s_ieme | ctl_s.s_mewb;

  // Saturating count of cycles with any hold asserted
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= {PERF_W{1'b0}};
    end else if (any_stall_s && (stall_cnt_r != {PERF_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(PERF_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign s_PC      = ctl_s.s_pc;
  assign b_IFID    = ctl_s.b_ifid;
  assign b_IDIE    = ctl_s.b_idie;
  assign b_IEME    = ctl_s.b_ieme;
  assign b_MEWB    = ctl_s.b_mewb;
  assign s_IFID    = ctl_s.s_ifid;
  assign s_IDIE    = ctl_s.s_idie;
  assign s_IEME    = ctl_s.s_ieme;
  assign s_MEWB    = ctl_s.s_mewb;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed self-checking bench for hazard_ctrl_mc (MULDIV_LAT=4, narrow counter).
module tb_hazard_ctrl_mc;
  import hazard_ctrl_mc_pkg::*;

  localparam int PW = 5;

  // Control bundle order: s_PC b_IFID b_IDIE b_IEME b_MEWB s_IFID s_IDIE s_IEME s_MEWB
  localparam logic [8:0] C_NONE  = 9'b0_0000_0000;
  localparam logic [8:0] C_RST   = 9'b0_1111_0000;
  localparam logic [8:0] C_FRZ   = 9'b1_0000_1111;
  localparam logic [8:0] C_FLUSH = 9'b0_1110_0000;
  localparam logic [8:0] C_MD    = 9'b1_0010_1100;
  localparam logic [8:0] C_LU    = 9'b1_0100_1000;
  localparam logic [8:0] C_IM    = 9'b1_1000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    rs1s2, rs2s2, rds3;
  logic          useRs1s2, useRs2s2, regesterWs3, muldivs3, jumps4;
  logic [1:0]    regSrcs3, jumpSels4;
  logic          imem_ready, dmem_reqs4, dmem_ready;
  logic          s_PC, b_IFID, b_IDIE, b_IEME, b_MEWB, s_IFID, s_IDIE, s_IEME, s_MEWB;
  logic [PW-1:0] stall_cnt;
  logic [8:0]    ctl;

  int n_checks = 0;
  int n_fail   = 0;

  assign ctl = {s_PC, b_IFID, b_IDIE, b_IEME, b_MEWB, s_IFID, s_IDIE, s_IEME, s_MEWB};

  hazard_ctrl_mc #(.REG_AW(5), .MULDIV_LAT(4), .PERF_W(PW)) dut (
    .clk(clk), .rst(rst),
    .rs1s2(rs1s2), .rs2s2(rs2s2), .useRs1s2(useRs1s2), .useRs2s2(useRs2s2),
    .rds3(rds3), .regesterWs3(regesterWs3), .regSrcs3(regSrcs3), .muldivs3(muldivs3),
    .jumps4(jumps4), .jumpSels4(jumpSels4), .imem_ready(imem_ready),
    .dmem_reqs4(dmem_reqs4), .dmem_ready(dmem_ready),
    .s_PC(s_PC), .b_IFID(b_IFID), .b_IDIE(b_IDIE), .b_IEME(b_IEME), .b_MEWB(b_MEWB),
    .s_IFID(s_IFID), .s_IDIE(s_IDIE), .s_IEME(s_IEME), .s_MEWB(s_MEWB),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rs1s2 = 5'd0; rs2s2 = 5'd0; rds3 = 5'd0;
    useRs1s2 = 1'b0; useRs2s2 = 1'b0; regesterWs3 = 1'b0; regSrcs3 = REGSRC_ALU;
    muldivs3 = 1'b0; jumps4 = 1'b0; jumpSels4 = PJUMP_PC4;
    imem_ready = 1'b1; dmem_reqs4 = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #2;
    n_checks++;
    if (ctl !== C_RST) begin n_fail++; $display("FAIL reset_ctl got %b want %b", ctl, C_RST); end
    tick();
    n_checks++;
    if (stall_cnt !== 5'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", stall_cnt); end
    n_checks++;
    if (ctl !== C_RST) begin n_fail++; $display("FAIL reset_ctl_held got %b want %b", ctl, C_RST); end
    rst = 1'b0;
    #2;
    n_checks++;
    if (ctl !== C_NONE) begin n_fail++; $display("FAIL reset_release got %b want %b", ctl, C_NONE); end
    tick();
  endtask

  typedef struct packed {
    logic [4:0] rd; logic [1:0] src; logic we;
    logic [4:0] r1; logic u1; logic [4:0] r2; logic u2; logic [8:0] exp;
  } lu_vec_t;

  task automatic test_loaduse();
    lu_vec_t tbl [8];
    tbl[0] = '{5'd5,  2'd1, 1'b1, 5'd7, 1'b1, 5'd5,  1'b1, C_LU};
    tbl[1] = '{5'd0,  2'd1, 1'b1, 5'd0, 1'b1, 5'd0,  1'b1, C_NONE};
    tbl[2] = '{5'd9,  2'd3, 1'b1, 5'd9, 1'b1, 5'd2,  1'b0, C_LU};
    tbl[3] = '{5'd9,  2'd3, 1'b1, 5'd9, 1'b0, 5'd2,  1'b1, C_NONE};
    tbl[4] = '{5'd9,  2'd0, 1'b1, 5'd9, 1'b1, 5'd9,  1'b1, C_NONE};
    tbl[5] = '{5'd9,  2'd2, 1'b1, 5'd9, 1'b1, 5'd9,  1'b1, C_NONE};
    tbl[6] = '{5'd9,  2'd1, 1'b0, 5'd9, 1'b1, 5'd9,  1'b1, C_NONE};
    tbl[7] = '{5'd31, 2'd1, 1'b1, 5'd3, 1'b1, 5'd31, 1'b1, C_LU};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      rds3 = tbl[i].rd; regSrcs3 = tbl[i].src; regesterWs3 = tbl[i].we;
      rs1s2 = tbl[i].r1; useRs1s2 = tbl[i].u1; rs2s2 = tbl[i].r2; useRs2s2 = tbl[i].u2;
      #2;
      n_checks++;
      if (ctl !== tbl[i].exp) begin n_fail++; $display("FAIL loaduse_v%0d got %b want %b", i, ctl, tbl[i].exp); end
      tick();
      // The load has moved on and a bubble now occupies EX
      regesterWs3 = 1'b0;
      #2;
      n_checks++;
      if (ctl !== C_NONE) begin n_fail++; $display("FAIL loaduse_after_v%0d got %b want %b", i, ctl, C_NONE); end
      tick();
    end
    n_checks++;
    if (stall_cnt !== 5'd3) begin n_fail++; $display("FAIL loaduse_cnt got %0d want 3", stall_cnt); end
  endtask

  task automatic test_muldiv();
    logic [8:0] seq [8];
    seq = '{C_MD, C_MD, C_MD, C_NONE, C_MD, C_MD, C_MD, C_NONE};
    do_reset();
    muldivs3 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #2;
      n_checks++;
      if (ctl !== seq[i]) begin n_fail++; $display("FAIL muldiv_c%0d got %b want %b", i, ctl, seq[i]); end
      if (i == 4) begin
        n_checks++;
        if (stall_cnt !== 5'd3) begin n_fail++; $display("FAIL muldiv_cnt1 got %0d want 3", stall_cnt); end
      end
      tick();
    end
    muldivs3 = 1'b0;
    #2;
    n_checks++;
    if (ctl !== C_NONE) begin n_fail++; $display("FAIL muldiv_idle got %b want %b", ctl, C_NONE); end
    n_checks++;
    if (stall_cnt !== 5'd6) begin n_fail++; $display("FAIL muldiv_cnt2 got %0d want 6", stall_cnt); end
    tick();
  endtask

  task automatic test_jump_abort();
    logic [8:0] seq [6];
    seq = '{C_MD, C_FLUSH, C_MD, C_MD, C_MD, C_NONE};
    do_reset();
    muldivs3 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      jumps4    = (i == 1);
      jumpSels4 = (i == 1) ? JSEL_BRANCH : PJUMP_PC4;
      #2;
      n_checks++;
      if (ctl !== seq[i]) begin n_fail++; $display("FAIL jump_abort_c%0d got %b want %b", i, ctl, seq[i]); end
      tick();
    end
    n_checks++;
    if (stall_cnt !== 5'd4) begin n_fail++; $display("FAIL jump_abort_cnt got %0d want 4", stall_cnt); end
    idle_inputs();
  endtask

  task automatic test_memwait();
    logic [8:0] seq [11];
    seq = '{C_MD, C_FRZ, C_FRZ, C_FRZ, C_MD, C_MD, C_NONE, C_NONE, C_FRZ, C_IM, C_NONE};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      muldivs3   = (i <= 6);
      dmem_reqs4 = (i >= 1 && i <= 4) || (i == 8) || (i == 9);
      dmem_ready = !((i >= 1 && i <= 3) || (i == 8));
      jumps4     = (i == 2);
      jumpSels4  = (i == 2) ? JSEL_JAL : PJUMP_PC4;
      imem_ready = (i != 9);
      #2;
      n_checks++;
      if (ctl !== seq[i]) begin n_fail++; $display("FAIL memwait_c%0d got %b want %b", i, ctl, seq[i]); end
      if (i == 7) begin
        n_checks++;
        if (stall_cnt !== 5'd6) begin n_fail++; $display("FAIL memwait_cnt got %0d want 6", stall_cnt); end
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_priority();
    // {jumps4, jumpSels4, loaduse_on, imem_ready, muldivs3, expected}
    logic [14:0] tbl [9];
    tbl[0] = {1'b1, 2'd1, 1'b1, 1'b1, 1'b0, C_FLUSH};
    tbl[1] = {1'b1, 2'd3, 1'b1, 1'b0, 1'b0, C_FLUSH};
    tbl[2] = {1'b1, 2'd0, 1'b1, 1'b1, 1'b0, C_LU};
    tbl[3] = {1'b1, 2'd0, 1'b0, 1'b0, 1'b0, C_IM};
    tbl[4] = {1'b0, 2'd1, 1'b0, 1'b1, 1'b0, C_NONE};
    tbl[5] = {1'b0, 2'd2, 1'b1, 1'b0, 1'b0, C_LU};
    tbl[6] = {1'b0, 2'd0, 1'b0, 1'b0, 1'b0, C_IM};
    tbl[7] = {1'b1, 2'd2, 1'b0, 1'b1, 1'b1, C_FLUSH};
    tbl[8] = {1'b0, 2'd0, 1'b0, 1'b1, 1'b0, C_NONE};
    do_reset();
    rds3 = 5'd4; rs1s2 = 5'd4; useRs1s2 = 1'b1; regSrcs3 = REGSRC_MEM;
    for (int i = 0; i < 9; i++) begin
      jumps4      = tbl[i][14];
      jumpSels4   = tbl[i][13:12];
      regesterWs3 = tbl[i][11];
      imem_ready  = tbl[i][10];
      muldivs3    = tbl[i][9];
      #2;
      n_checks++;
      if (ctl !== tbl[i][8:0]) begin n_fail++; $display("FAIL priority_v%0d got %b want %b", i, ctl, tbl[i][8:0]); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset_memwait();
    do_reset();
    dmem_reqs4 = 1'b1; dmem_ready = 1'b0;
    tick();
    tick();
    #2;
    n_checks++;
    if (stall_cnt !== 5'd2) begin n_fail++; $display("FAIL rstmw_cnt_pre got %0d want 2", stall_cnt); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (ctl !== C_RST) begin n_fail++; $display("FAIL rstmw_ctl got %b want %b", ctl, C_RST); end
    tick();
    rst = 1'b0; dmem_reqs4 = 1'b0;
    #2;
    n_checks++;
    if (ctl !== C_NONE) begin n_fail++; $display("FAIL rstmw_idle got %b want %b", ctl, C_NONE); end
    n_checks++;
    if (stall_cnt !== 5'd0) begin n_fail++; $display("FAIL rstmw_cnt got %0d want 0", stall_cnt); end
    tick();
    idle_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    dmem_reqs4 = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 20) begin
        n_checks++;
        if (stall_cnt !== 5'd20) begin n_fail++; $display("FAIL sat_mid got %0d want 20", stall_cnt); end
      end
      tick();
    end
    #2;
    n_checks++;
    if (stall_cnt !== 5'd31) begin n_fail++; $display("FAIL sat_max got %0d want 31", stall_cnt); end
    n_checks++;
    if (ctl !== C_FRZ) begin n_fail++; $display("FAIL sat_ctl got %b want %b", ctl, C_FRZ); end
    tick();
    n_checks++;
    if (stall_cnt !== 5'd31) begin n_fail++; $display("FAIL sat_hold got %0d want 31", stall_cnt); end
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_loaduse();
    test_muldiv();
    test_jump_abort();
    test_memwait();
    test_priority();
    test_reset_memwait();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
